// File: rtl/bouncing_box_gfx.sv
// Pixel colour source for the VGA timing block: a solid box on a flat background that
// moves SPEED px per frame and bounces off the visible edges, updating only at frame start.
module bouncing_box_gfx #(
   parameter int          HPIXELS = 640,
   parameter int          VPIXELS = 480,
   parameter int          BOX_W   = 32,
   parameter int          BOX_H   = 32,
   parameter int          SPEED   = 2,
   parameter logic [7:0]  FG_RGB  = 8'hE0,
   parameter logic [7:0]  BG_RGB  = 8'h03
) (
   input  logic        vgaclk,
   input  logic        rst,
   input  logic [9:0]  hc,
   input  logic [9:0]  vc,
   input  logic        pause,
   output logic [2:0]  red,
   output logic [2:0]  green,
   output logic [1:0]  blue,
   output logic [9:0]  box_x,
   output logic [9:0]  box_y,
   output logic        frame_tick,
   output logic [7:0]  bounce_count
);

   localparam logic [10:0] L_HP   = 11'(HPIXELS);
   localparam logic [10:0] L_VP   = 11'(VPIXELS);
   localparam logic [10:0] L_BW   = 11'(BOX_W);
   localparam logic [10:0] L_BH   = 11'(BOX_H);
   localparam logic [10:0] L_SP   = 11'(SPEED);
   localparam logic [9:0]  L_X0   = 10'((HPIXELS - BOX_W) / 2);
   localparam logic [9:0]  L_Y0   = 10'((VPIXELS - BOX_H) / 2);
   localparam logic [9:0]  L_XMAX = 10'(HPIXELS - BOX_W);
   localparam logic [9:0]  L_YMAX = 10'(VPIXELS - BOX_H);
   localparam logic [9:0]  L_STEP = 10'(SPEED);

   typedef enum logic [1:0] {
      RIGHT_DOWN = 2'b00,
      RIGHT_UP   = 2'b01,
      LEFT_DOWN  = 2'b10,
      LEFT_UP    = 2'b11
   } motion_t;

   motion_t     r_state;
   logic [9:0]  r_box_x;
   logic [9:0]  r_box_y;
   logic        r_tick;
   logic [7:0]  r_bcnt;

   logic [10:0] w_hc, w_vc, w_x, w_y;
   logic        w_slot, w_left, w_up, w_bx, w_by, w_inside;
   logic [9:0]  w_nx, w_ny;
   motion_t     w_nstate;

   assign w_hc   = {1'b0, hc};
   assign w_vc   = {1'b0, vc};
   assign w_x    = {1'b0, r_box_x};
   assign w_y    = {1'b0, r_box_y};
   assign w_slot = (w_hc == 11'd0) && (w_vc == L_VP);
   assign w_left = (r_state == LEFT_DOWN) || (r_state == LEFT_UP);
   assign w_up   = (r_state == RIGHT_UP)  || (r_state == LEFT_UP);

   // A bounce clamps to the wall and reverses direction without also stepping
   always_comb begin
      w_bx = 1'b0;
      w_nx = r_box_x;
      if (!w_left) begin
         if (w_x + L_BW + L_SP > L_HP) begin
            w_bx = 1'b1;
            w_nx = L_XMAX;
         end else begin
            w_nx = r_box_x + L_STEP;
         end
      end else begin
         if (w_x < L_SP) begin
            w_bx = 1'b1;
            w_nx = '0;
         end else begin
            w_nx = r_box_x - L_STEP;
         end
      end
      w_by = 1'b0;
      w_ny = r_box_y;
      if (!w_up) begin
         if (w_y + L_BH + L_SP > L_VP) begin
            w_by = 1'b1;
            w_ny = L_YMAX;
         end else begin
            w_ny = r_box_y + L_STEP;
         end
      end else begin
         if (w_y < L_SP) begin
            w_by = 1'b1;
            w_ny = '0;
         end else begin
            w_ny = r_box_y - L_STEP;
         end
      end
      w_nstate = motion_t'({w_left ^ w_bx, w_up ^ w_by});
   end

   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
         r_box_x <= L_X0;
         r_box_y <= L_Y0;
         r_state <= RIGHT_DOWN;
         r_tick  <= 1'b0;
         r_bcnt  <= 8'd0;
      end else begin
         r_tick <= w_slot;
         if (w_slot && !pause) begin
            r_box_x <= w_nx;
            r_box_y <= w_ny;
            r_state <= w_nstate;
            if ((w_bx || w_by) && (r_bcnt != 8'hFF))
               r_bcnt <= r_bcnt + 8'd1;
         end
      end
   end

   // Zero-latency colour: depends only on the live counters and the held position
   assign w_inside = (w_hc >= w_x) && (w_hc < w_x + L_BW) &&
                     (w_vc >= w_y) && (w_vc < w_y + L_BH);
   assign {red, green, blue} = w_inside ? FG_RGB : BG_RGB;

   assign box_x        = r_box_x;
   assign box_y        = r_box_y;
   assign frame_tick   = r_tick;
   assign bounce_count = r_bcnt;

endmodule

// File: tb/tb_bouncing_box_gfx.sv
// Randomised bench for bouncing_box_gfx: compressed frames (a few pixels plus the update
// slot) checked against a plain-arithmetic model of the box motion and colour rule.
module tb_bouncing_box_gfx;

   logic        vgaclk = 1'b0;
   logic        rst;
   logic [9:0]  hc;
   logic [9:0]  vc;
   logic        pause;
   logic [2:0]  red;
   logic [2:0]  green;
   logic [1:0]  blue;
   logic [9:0]  box_x;
   logic [9:0]  box_y;
   logic        frame_tick;
   logic [7:0]  bounce_count;

   bouncing_box_gfx dut (
      .vgaclk       (vgaclk),
      .rst          (rst),
      .hc           (hc),
      .vc           (vc),
      .pause        (pause),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .box_x        (box_x),
      .box_y        (box_y),
      .frame_tick   (frame_tick),
      .bounce_count (bounce_count)
   );

   always #5 vgaclk = ~vgaclk;

   int n_cmp = 0;
   int n_bad = 0;
   int mx, my, mdx, mdy, mcnt;
   int frame_no;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic model_reset();
      mx = 304; my = 224; mdx = 1; mdy = 1; mcnt = 0;
   endtask

   // Box rules from the behaviour description: step, or clamp to the wall and turn around
   task automatic model_slot(input logic p);
      bit b;
      if (p) return;
      b = 0;
      if (mdx > 0) begin
         if (mx + 32 + 2 > 640) begin mx = 608; mdx = -1; b = 1; end
         else mx = mx + 2;
      end else begin
         if (mx < 2) begin mx = 0; mdx = 1; b = 1; end
         else mx = mx - 2;
      end
      if (mdy > 0) begin
         if (my + 32 + 2 > 480) begin my = 448; mdy = -1; b = 1; end
         else my = my + 2;
      end else begin
         if (my < 2) begin my = 0; mdy = 1; b = 1; end
         else my = my - 2;
      end
      if (b && mcnt < 255) mcnt++;
   endtask

   function automatic logic [7:0] model_rgb(input int h, input int v);
      if (h >= mx && h < mx + 32 && v >= my && v < my + 32) return 8'hE0;
      return 8'h03;
   endfunction

   task automatic drive(input int h, input int v);
      @(negedge vgaclk);
      hc = 10'(h);
      vc = 10'(v);
   endtask

   task automatic pix_check(input int h, input int v);
      drive(h, v);
      #1;
      check("rgb", {24'd0, red, green, blue}, {24'd0, model_rgb(h, v)});
   endtask

   // Pixel near the box edges (or anywhere visible), clamped into the visible area
   task automatic rand_pix();
      int h, v;
      if ($urandom_range(0, 3) == 0) begin
         h = $urandom_range(0, 639);
         v = $urandom_range(0, 479);
      end else begin
         h = mx + $urandom_range(0, 38) - 3;
         v = my + $urandom_range(0, 38) - 3;
         if (h < 0) h = 0;
         if (h > 639) h = 639;
         if (v < 0) v = 0;
         if (v > 479) v = 479;
      end
      pix_check(h, v);
   endtask

   task automatic frame(input logic p);
      pause = p;
      rand_pix();
      rand_pix();
      drive(0, 480);
      @(posedge vgaclk);
      #1;
      model_slot(p);
      frame_no++;
      check("tick_hi", {31'd0, frame_tick}, 32'd1);
      check("box_x", {22'd0, box_x}, mx);
      check("box_y", {22'd0, box_y}, my);
      check("bounce_count", {24'd0, bounce_count}, mcnt);
      drive(1, 480);
      @(posedge vgaclk);
      #1;
      check("tick_lo", {31'd0, frame_tick}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; pause = 1'b0; hc = 10'd0; vc = 10'd0;
      frame_no = 0;
      model_reset();
      repeat (3) @(posedge vgaclk);
      @(negedge vgaclk);
      rst = 1'b0;
      repeat (2) @(posedge vgaclk);
      #1;
      check("rst_box_x", {22'd0, box_x}, 32'd304);
      check("rst_box_y", {22'd0, box_y}, 32'd224);
      check("rst_bounce", {24'd0, bounce_count}, 32'd0);
      check("rst_tick", {31'd0, frame_tick}, 32'd0);
      pix_check(304, 224);
      check("rgb_corner", {24'd0, red, green, blue}, 32'hE0);
      pix_check(336, 224);
      check("rgb_right_out", {24'd0, red, green, blue}, 32'h03);
      pix_check(303, 224);
      check("rgb_left_out", {24'd0, red, green, blue}, 32'h03);

      // Unpaused run through the first vertical and horizontal bounces to the left wall
      for (int f = 1; f <= 460; f++) begin
         frame(1'b0);
         case (f)
            1:   begin check("f1_x", {22'd0, box_x}, 32'd306); check("f1_y", {22'd0, box_y}, 32'd226); end
            112: check("f112_y", {22'd0, box_y}, 32'd448);
            113: begin check("f113_y", {22'd0, box_y}, 32'd448); check("f113_cnt", {24'd0, bounce_count}, 32'd1); end
            114: check("f114_y", {22'd0, box_y}, 32'd446);
            152: check("f152_x", {22'd0, box_x}, 32'd608);
            153: begin check("f153_x", {22'd0, box_x}, 32'd608); check("f153_cnt", {24'd0, bounce_count}, 32'd2); end
            154: check("f154_x", {22'd0, box_x}, 32'd606);
            338: begin check("f338_y", {22'd0, box_y}, 32'd0); check("f338_cnt", {24'd0, bounce_count}, 32'd3); end
            458: begin check("f458_x", {22'd0, box_x}, 32'd0); check("f458_cnt", {24'd0, bounce_count}, 32'd4); end
            459: check("f459_x", {22'd0, box_x}, 32'd2);
            default: ;
         endcase
      end

      // Random pause pattern
      for (int f = 0; f < 80; f++)
         frame($urandom_range(0, 3) == 0);

      // Five paused slots: ticks still pulse, nothing moves
      begin
         int hx, hy, hc_cnt;
         hx = mx; hy = my; hc_cnt = mcnt;
         for (int f = 0; f < 5; f++) frame(1'b1);
         check("pause_x", {22'd0, box_x}, hx);
         check("pause_y", {22'd0, box_y}, hy);
         check("pause_cnt", {24'd0, bounce_count}, hc_cnt);
         frame(1'b0);
      end

      // Asynchronous reset right after a slot, between clock edges
      pause = 1'b0;
      drive(0, 480);
      @(posedge vgaclk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_box_x", {22'd0, box_x}, 32'd304);
      check("arst_box_y", {22'd0, box_y}, 32'd224);
      check("arst_cnt", {24'd0, bounce_count}, 32'd0);
      check("arst_tick", {31'd0, frame_tick}, 32'd0);
      drive(5, 10);
      @(negedge vgaclk);
      rst = 1'b0;
      model_reset();
      drive(6, 10);
      @(posedge vgaclk);
      #1;
      check("post_rst_hold_x", {22'd0, box_x}, 32'd304);
      frame(1'b0);
      check("post_rst_x", {22'd0, box_x}, 32'd306);
      check("post_rst_y", {22'd0, box_y}, 32'd226);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
